// File: rtl/change_pkg.sv
// change_pkg: coin codes, coin value table, FSM states and amount width for the change dispenser
package change_pkg;
  localparam int AW = 11;
  typedef enum logic [2:0] {C_NONE, C_1, C_2, C_5, C_10, C_20, C_50} coin_t;
  typedef enum logic [1:0] {IDLE, SELECT, EJECT, DONE} state_t;
  localparam logic [AW-1:0] COIN_VAL [8] = '{11'd0, 11'd1, 11'd2, 11'd5, 11'd10, 11'd20, 11'd50, 11'd0};
  function automatic logic [AW-1:0] coin_value(input logic [2:0] c);
    return COIN_VAL[c];
  endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, ejector, refill and completion signals of the change dispenser
interface change_dispenser_if;
  import change_pkg::*;
  logic req_valid, req_ready;
  logic [AW-1:0] req_amount;
  logic eject_valid, eject_ready;
  logic [2:0] eject_coin;
  logic refill_valid;
  logic [2:0] refill_coin;
  logic [7:0] refill_cnt;
  logic done, error;
  logic [AW-1:0] short_amount;
  modport slave(input req_valid, req_amount, eject_ready, refill_valid, refill_coin, refill_cnt,
                output req_ready, eject_valid, eject_coin, done, short_amount, error);
  modport master(output req_valid, req_amount, eject_ready, refill_valid, refill_coin, refill_cnt,
                 input req_ready, eject_valid, eject_coin, done, short_amount, error);
endinterface

// File: rtl/change_dispenser_coin_selector.sv
// coin_selector: largest non-empty coin whose value fits in the remaining amount
module coin_selector
  import change_pkg::*;
(
  input  logic [AW-1:0] remaining,
  input  logic [5:0]    nonempty,
  output logic          valid,
  output logic [2:0]    coin
);
  always_comb begin
    valid = 1'b0;
    coin = C_NONE;
    for (int i = 0; i < 6; i++)
      if (nonempty[i] && coin_value(3'(i + 1)) <= remaining) begin
        valid = 1'b1;
        coin = 3'(i + 1);
      end
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy change payout from six saturating coin tubes
module change_dispenser
  import change_pkg::*;
#(
  parameter int TUBE_INIT = 8,
  parameter int TUBE_MAX  = 255
) (
  input logic clk,
  input logic rst,
  change_dispenser_if.slave bus
);
  state_t state, nxt;
  logic [AW-1:0] remaining;
  logic [2:0] coin, sel_coin;
  logic sel_valid, eject_hs;
  logic [5:0] nonempty;
  assign eject_hs = state == EJECT && bus.eject_ready;
  coin_selector u_sel (.remaining(remaining), .nonempty(nonempty), .valid(sel_valid), .coin(sel_coin));
  // Refill and eject may hit the same tube in one cycle; both are folded into one saturating update.
  for (genvar g = 0; g < 6; g++) begin : g_tube
    logic [7:0] cnt;
    logic [8:0] sum;
    assign sum = {1'b0, cnt}
               + (bus.refill_valid && bus.refill_coin == 3'(g + 1) ? {1'b0, bus.refill_cnt} : 9'd0)
               - {8'd0, eject_hs && coin == 3'(g + 1)};
    assign nonempty[g] = |cnt;
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= 8'(TUBE_INIT);
      else cnt <= sum > 9'(TUBE_MAX) ? 8'(TUBE_MAX) : sum[7:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE   ? (bus.req_valid ? SELECT : IDLE) :
          state == SELECT ? (sel_valid ? EJECT : DONE) :
          state == EJECT  ? (bus.eject_ready ? SELECT : EJECT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      remaining <= '0;
      coin <= C_NONE;
      bus.short_amount <= '0;
      bus.error <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) remaining <= bus.req_amount;
      if (state == SELECT) begin
        coin <= sel_coin;
        if (!sel_valid) begin
          bus.short_amount <= remaining;
          bus.error <= |remaining;
        end
      end
      if (eject_hs) remaining <= remaining - coin_value(coin);
    end
  assign bus.req_ready = state == IDLE;
  assign bus.eject_valid = state == EJECT;
  assign bus.eject_coin = state == EJECT ? coin : C_NONE;
  assign bus.done = state == DONE;
endmodule
